// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared constants and the FSM state encoding for the
// dmem_responder slice.
package dmem_resp_pkg;

  localparam int WORD_W    = 32;
  localparam int DEPTH_DEF = 64;
  localparam int LAT_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: request/response handshake between an initiator (master)
// and the data-memory responder (slave).
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   resp_valid/resp_ready/resp_rdata/resp_err        : response channel
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp_array.sv
// dmem_resp_array: word storage for dmem_responder.
//   clock, reset : clock, asynchronous active-high clear of every word
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational read port (sampled by the owner)
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// response latency.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : dmem_resp_if.slave (request + response channels)
// Stores commit on the acceptance edge; loads sample the array on that same
// edge, so the response only waits out LATENCY.
// Optional feature: define DMEM_RESP_ALIGN_CHECK_EN to reject requests whose
// byte address is not word aligned (no store, resp_err=1, resp_rdata=0).
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_DEF,
  parameter int LATENCY     = LAT_DEF
) (
  input  logic         clock,
  input  logic         reset,
  dmem_resp_if.slave   bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  // WAIT lasts LATENCY-1 cycles; counter counts down to 0 before RESP.
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [IW-1:0]     idx;
  logic              misalign;
  logic              accept;
  logic              we;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  // Upper address bits are dropped so addresses wrap modulo 4*DEPTH_WORDS.
  assign idx = bus.req_addr[IW+1:2];

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  logic unused_addr;
  assign misalign    = |bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[31:IW+2];
`else
  logic unused_addr;
  assign misalign    = 1'b0;
  assign unused_addr = ^{bus.req_addr[31:IW+2], bus.req_addr[1:0]};
`endif

  assign accept = (state == IDLE) && bus.req_valid;
  assign we     = accept && bus.req_write && !misalign;

  dmem_resp_array #(.DEPTH(DEPTH_WORDS), .AW(IW)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (idx),
    .wdata (bus.req_wdata),
    .raddr (idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
          cnt_n   = CNT_LOAD;
        end
      end
      WAIT: if (cnt == '0) state_n = RESP;
            else           cnt_n   = cnt - 4'd1;
      RESP: if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response payload is frozen at acceptance, which keeps it stable under
  // backpressure. Stores and rejected requests return zero data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (bus.req_write || misalign) ? '0 : rd_word;
      err_q   <= misalign;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = (state == RESP) ? rdata_q : '0;
  assign bus.resp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench. u0 uses the default parameters
// (DEPTH_WORDS=64, LATENCY=2); u1 runs LATENCY=1 for back-to-back loads.
module tb_dmem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nvec  = 0;
  int   nerr  = 0;

  always #5 clock = ~clock;

  dmem_resp_if b0 ();
  dmem_resp_if b1 ();

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u0 (
    .clock (clock), .reset (reset), .bus (b0.slave)
  );
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u1 (
    .clock (clock), .reset (reset), .bus (b1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge with u0 idle. Returns payload and the number
  // of edges from acceptance (inclusive) to resp_valid being seen.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    b0.req_write = wr;
    b0.req_addr  = addr;
    b0.req_wdata = wdata;
    b0.req_valid = 1'b1;
    chk("req_ready_idle", 32'(b0.req_ready), 32'd1);
    @(posedge clock); #1;
    b0.req_valid = 1'b0;
    lat = 1;
    while (!b0.resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = b0.resp_rdata;
    er = b0.resp_err;
  endtask

  task automatic consume();
    b0.resp_ready = 1'b1;
    @(posedge clock); #1;
    b0.resp_ready = 1'b0;
    chk("idle_after_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("idle_after_resp_ready", 32'(b0.req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    b0.req_valid = 0; b0.req_write = 0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 0;
    b1.req_valid = 0; b1.req_write = 0; b1.req_addr = '0; b1.req_wdata = '0; b1.resp_ready = 0;

    // reset state
    @(posedge clock); #1;
    chk("rst_req_ready",  32'(b0.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_resp_rdata", b0.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(b0.resp_err),   32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // store then load, latency 2
    do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st10_lat",   32'(lat), 32'd2);
    chk("st10_rdata", rd,       32'd0);
    chk("st10_err",   32'(er),  32'd0);
    consume();
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld10_lat",   32'(lat), 32'd2);
    chk("ld10_rdata", rd,       32'hDEADBEEF);
    consume();

    // backpressure: 5 stalled cycles; a store attempted meanwhile is ignored
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("stall_lat", 32'(lat), 32'd2);
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 32'h10; b0.req_wdata = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid",     32'(b0.resp_valid), 32'd1);
      chk("stall_rdata",     b0.resp_rdata,      32'hDEADBEEF);
      chk("stall_req_ready", 32'(b0.req_ready),  32'd0);
      @(posedge clock); #1;
    end
    b0.req_valid = 1'b0;
    consume();
    chk("stall_rdata_after", b0.resp_rdata, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ignored_store", rd, 32'hDEADBEEF);
    consume();

    // address wrap modulo 256 bytes
    do_req(1'b1, 32'h104, 32'h12345678, rd, er, lat);
    consume();
    do_req(1'b0, 32'h004, 32'h0, rd, er, lat);
    chk("wrap_rdata", rd, 32'h12345678);
    consume();

    // reset one cycle after accepting a store
    b0.req_write = 1'b1; b0.req_addr = 32'h20; b0.req_wdata = 32'h5A5A5A5A; b0.req_valid = 1'b1;
    @(posedge clock); #1;
    b0.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_valid",     32'(b0.resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(b0.req_ready),  32'd1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("midrst_no_resp", 32'(b0.resp_valid), 32'd0);
    end
    do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("midrst_ld20", rd, 32'd0);
    consume();
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("midrst_ld10_cleared", rd, 32'd0);
    consume();

    // misaligned store
    do_req(1'b1, 32'h22, 32'hAAAA5555, rd, er, lat);
    chk("mis_lat",   32'(lat), 32'd2);
    chk("mis_rdata", rd,       32'd0);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    chk("mis_err", 32'(er), 32'd1);
`else
    chk("mis_err", 32'(er), 32'd0);
`endif
    consume();
    chk("mis_err_cleared", 32'(b0.resp_err), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    chk("mis_ld20", rd, 32'd0);
`else
    chk("mis_ld20", rd, 32'hAAAA5555);
`endif
    consume();

    // LATENCY=1, back-to-back loads, resp_ready tied high
    b1.resp_ready = 1'b1;
    b1.req_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      chk("l1_resp_valid", 32'(b1.resp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("l1_req_ready",  32'(b1.req_ready),  (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    b1.req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
